// File: rtl/seq_alu.sv
// Sequential MIPS-style ALU: single-cycle integer ops plus multi-cycle
// shift-add multiply and restoring divide, both writing the HI/LO pair.
module seq_alu #(
  parameter int DATA_W     = 32,
  parameter bit SIGNED_DIV = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instruction,
  input  logic [DATA_W-1:0] reg_a,
  input  logic [DATA_W-1:0] reg_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic [2:0]        flags,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic              busy
);
  localparam int SH_W  = $clog2(DATA_W);
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [DATA_W-1:0] MIN_VAL = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_HOLD} state_t;

  state_t             state_q, state_d;
  logic               out_valid_q, out_valid_d;
  logic [DATA_W-1:0]  result_q, result_d;
  logic [2:0]         flags_q, flags_d;
  logic [DATA_W-1:0]  hi_q, hi_d, lo_q, lo_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  acc_q, acc_d, wrk_q, wrk_d, opnd_q, opnd_d, a_q, a_d;
  logic               neg_q, neg_d, rneg_q, rneg_d, dz_q, dz_d, ovf_q, ovf_d;

  logic [5:0]         opcode, funct, shamt_ext;
  logic [SH_W-1:0]    sh_imm, sh_var;
  logic [DATA_W-1:0]  imm_s, imm_z, sum_ab, diff_ab, sum_ai;
  logic [DATA_W-1:0]  sc_res, a_mag, b_mag;
  logic               sc_ov, sc_ok, is_mul, is_div, md_signed, a_neg, b_neg, accept;
  logic [DATA_W:0]    mul_sum, div_shift, div_diff;
  logic [2*DATA_W-1:0] prod_fin;
  logic [DATA_W-1:0]  q_fin, r_fin;
  logic               unused_ok;

  assign opcode    = instruction[31:26];
  assign funct     = instruction[5:0];
  assign shamt_ext = {1'b0, instruction[10:6]};
  assign sh_imm    = shamt_ext[SH_W-1:0];
  assign sh_var    = reg_a[SH_W-1:0];
  assign imm_s     = {{(DATA_W-16){instruction[15]}}, instruction[15:0]};
  assign imm_z     = {{(DATA_W-16){1'b0}}, instruction[15:0]};
  assign sum_ab    = reg_a + reg_b;
  assign diff_ab   = reg_a - reg_b;
  assign sum_ai    = reg_a + imm_s;
  assign unused_ok = ^{instruction[25:16], shamt_ext};

  assign in_ready  = rst_n && (state_q == S_IDLE) && !out_valid_q;
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flags     = flags_q;
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign busy      = (state_q == S_MUL) || (state_q == S_DIV);

  // Multiply/divide run on magnitudes; signs are reapplied when finishing.
  assign a_neg = md_signed && reg_a[DATA_W-1];
  assign b_neg = md_signed && reg_b[DATA_W-1];
  assign a_mag = a_neg ? -reg_a : reg_a;
  assign b_mag = b_neg ? -reg_b : reg_b;

  assign mul_sum   = {1'b0, acc_q} + (wrk_q[0] ? {1'b0, opnd_q} : '0);
  assign div_shift = {acc_q, wrk_q[DATA_W-1]};
  assign div_diff  = div_shift - {1'b0, opnd_q};
  assign prod_fin  = neg_q ? -{acc_q, wrk_q} : {acc_q, wrk_q};
  assign q_fin     = dz_q ? '1 : (ovf_q ? MIN_VAL : (neg_q ? -wrk_q : wrk_q));
  assign r_fin     = dz_q ? a_q : (ovf_q ? '0 : (rneg_q ? -acc_q : acc_q));

  always_comb begin
    sc_res    = '0;
    sc_ov     = 1'b0;
    sc_ok     = 1'b1;
    is_mul    = 1'b0;
    is_div    = 1'b0;
    md_signed = 1'b0;
    if (opcode == 6'h00) begin
      case (funct)
        6'h00: sc_res = reg_b << sh_imm;
        6'h02: sc_res = reg_b >> sh_imm;
        6'h03: sc_res = $signed(reg_b) >>> sh_imm;
        6'h04: sc_res = reg_b << sh_var;
        6'h06: sc_res = reg_b >> sh_var;
        6'h07: sc_res = $signed(reg_b) >>> sh_var;
        6'h10: sc_res = hi_q;
        6'h12: sc_res = lo_q;
        6'h18: begin is_mul = 1'b1; md_signed = 1'b1; end
        6'h19: is_mul = 1'b1;
        6'h1A: begin is_div = 1'b1; md_signed = SIGNED_DIV; end
        6'h1B: is_div = 1'b1;
        6'h20: begin
          sc_res = sum_ab;
          sc_ov  = (reg_a[DATA_W-1] == reg_b[DATA_W-1]) && (sum_ab[DATA_W-1] != reg_a[DATA_W-1]);
        end
        6'h21: sc_res = sum_ab;
        6'h22: begin
          sc_res = diff_ab;
          sc_ov  = (reg_a[DATA_W-1] != reg_b[DATA_W-1]) && (diff_ab[DATA_W-1] != reg_a[DATA_W-1]);
        end
        6'h23: sc_res = diff_ab;
        6'h24: sc_res = reg_a & reg_b;
        6'h25: sc_res = reg_a | reg_b;
        6'h26: sc_res = reg_a ^ reg_b;
        6'h27: sc_res = ~(reg_a | reg_b);
        6'h2A: sc_res = {{(DATA_W-1){1'b0}}, $signed(reg_a) < $signed(reg_b)};
        6'h2B: sc_res = {{(DATA_W-1){1'b0}}, reg_a < reg_b};
        default: sc_ok = 1'b0;
      endcase
    end else begin
      case (opcode)
        6'h08: begin
          sc_res = sum_ai;
          sc_ov  = (reg_a[DATA_W-1] == imm_s[DATA_W-1]) && (sum_ai[DATA_W-1] != reg_a[DATA_W-1]);
        end
        6'h09, 6'h23, 6'h2B: sc_res = sum_ai;
        6'h0A: sc_res = {{(DATA_W-1){1'b0}}, $signed(reg_a) < $signed(imm_s)};
        6'h0B: sc_res = {{(DATA_W-1){1'b0}}, reg_a < imm_s};
        6'h0C: sc_res = reg_a & imm_z;
        6'h0D: sc_res = reg_a | imm_z;
        6'h0E: sc_res = reg_a ^ imm_z;
        6'h04, 6'h05: sc_res = diff_ab;
        default: sc_ok = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    flags_d     = flags_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    wrk_d       = wrk_q;
    opnd_d      = opnd_q;
    a_d         = a_q;
    neg_d       = neg_q;
    rneg_d      = rneg_q;
    dz_d        = dz_q;
    ovf_d       = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (out_valid_q && out_ready) out_valid_d = 1'b0;
        if (accept) begin
          if (is_mul || is_div) begin
            state_d = is_mul ? S_MUL : S_DIV;
            cnt_d   = '0;
            acc_d   = '0;
            wrk_d   = a_mag;
            opnd_d  = b_mag;
            a_d     = reg_a;
            neg_d   = a_neg ^ b_neg;
            rneg_d  = a_neg;
            dz_d    = (reg_b == '0);
            ovf_d   = md_signed && (reg_a == MIN_VAL) && (reg_b == '1);
          end else begin
            out_valid_d = 1'b1;
            result_d    = sc_ok ? sc_res : '0;
            flags_d     = sc_ok ? {sc_res == '0, sc_res[DATA_W-1], sc_ov} : 3'b000;
          end
        end
      end
      S_MUL: begin
        if (cnt_q == CNT_W'(DATA_W)) begin
          state_d     = S_HOLD;
          out_valid_d = 1'b1;
          hi_d        = prod_fin[2*DATA_W-1:DATA_W];
          lo_d        = prod_fin[DATA_W-1:0];
          result_d    = prod_fin[DATA_W-1:0];
          flags_d     = {prod_fin == '0, prod_fin[2*DATA_W-1], 1'b0};
        end else begin
          cnt_d = cnt_q + 1'b1;
          acc_d = mul_sum[DATA_W:1];
          wrk_d = {mul_sum[0], wrk_q[DATA_W-1:1]};
        end
      end
      S_DIV: begin
        if (cnt_q == CNT_W'(DATA_W)) begin
          state_d     = S_HOLD;
          out_valid_d = 1'b1;
          hi_d        = r_fin;
          lo_d        = q_fin;
          result_d    = q_fin;
          flags_d     = {q_fin == '0, q_fin[DATA_W-1], dz_q || ovf_q};
        end else begin
          cnt_d = cnt_q + 1'b1;
          // Restoring step: keep the trial subtraction only when it stays non-negative.
          if (!div_diff[DATA_W]) begin
            acc_d = div_diff[DATA_W-1:0];
            wrk_d = {wrk_q[DATA_W-2:0], 1'b1};
          end else begin
            acc_d = div_shift[DATA_W-1:0];
            wrk_d = {wrk_q[DATA_W-2:0], 1'b0};
          end
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= 3'b000;
      hi_q        <= '0;
      lo_q        <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      wrk_q       <= '0;
      opnd_q      <= '0;
      a_q         <= '0;
      neg_q       <= 1'b0;
      rneg_q      <= 1'b0;
      dz_q        <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      wrk_q       <= wrk_d;
      opnd_q      <= opnd_d;
      a_q         <= a_d;
      neg_q       <= neg_d;
      rneg_q      <= rneg_d;
      dz_q        <= dz_d;
      ovf_q       <= ovf_d;
    end
  end
endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter DATA_W, default 32, datapath width; legal values 16, 32, 64.
REQ-002 Parameter SIGNED_DIV, default 1, enables signed div (funct 0x1A); when 0, div executes as divu.
REQ-003 clk  input  1  rising-edge clock, single clock domain.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  request accepted on an edge where in_valid && in_ready.
REQ-007 instruction  input  32  MIPS encoding (opcode [31:26], shamt [10:6], funct [5:0], imm [15:0]).
REQ-008 reg_a  input  DATA_W  rs operand.
REQ-009 reg_b  input  DATA_W  rt operand.
REQ-010 out_valid  output  1  result/flags valid; held until out_ready.
REQ-011 out_ready  input  1  consumer accepts on edge where out_valid && out_ready.
REQ-012 result  output  DATA_W  operation result.
REQ-013 flags  output  3  [2] zero, [1] negative (result MSB), [0] signed overflow.
REQ-014 hi, lo  output  DATA_W each  architectural HI/LO registers.
REQ-015 busy  output  1  high in MUL or DIV state.

Function
REQ-016 FSM states IDLE, MUL, DIV, HOLD; one request outstanding at a time.
REQ-017 in_ready = (state==IDLE) && !out_valid.
REQ-018 Single-cycle ops: accept at edge N -> out_valid, result, flags registered at edge N; state stays IDLE.
REQ-019 R-type funct: add 0x20, addu 0x21, sub 0x22, subu 0x23, and 0x24, or 0x25, xor 0x26, nor 0x27, slt 0x2A, sltu 0x2B; sub = reg_a - reg_b.
REQ-020 Shifts operate on reg_b: sll/srl/sra (0x00/0x02/0x03) by shamt; sllv/srlv/srav (0x04/0x06/0x07) by reg_a; amount uses low log2(DATA_W) bits (shamt zero-extended when DATA_W=16 truncates to 4 bits).
REQ-021 I-type: addi 0x08, addiu 0x09, slti 0x0A, sltiu 0x0B, beq 0x04, bne 0x05, lw 0x23, sw 0x2B sign-extend imm to DATA_W; andi 0x0C, ori 0x0D, xori 0x0E zero-extend; operand is reg_a.
REQ-022 beq/bne: result = reg_a - reg_b; lw/sw: result = reg_a + sext(imm).
REQ-023 flags[0] set only for add, sub, addi on signed overflow; result still the wrapped sum; all other single-cycle ops clear it.
REQ-024 mfhi 0x10 / mflo 0x12: result = hi / lo, single-cycle.
REQ-025 mult 0x18, multu 0x19: enter MUL; radix-2 shift-add, exactly DATA_W iteration cycles, then HOLD.
REQ-026 div 0x1A, divu 0x1B: enter DIV; restoring division, exactly DATA_W iteration cycles, then HOLD.
REQ-027 Mult/div latency: accepted at edge N -> out_valid rises at edge N+DATA_W+1; hi/lo update on that same edge.
REQ-028 Mult: {hi,lo} = 2*DATA_W-bit product; result = lo; flags[2] = ({hi,lo}==0); flags[1] = hi MSB; flags[0]=0.
REQ-029 Div: lo = quotient truncated toward zero, hi = remainder with dividend's sign; result = lo.
REQ-030 Divide by zero: completes in normal latency; lo = all ones, hi = reg_a; flags[0]=1.
REQ-031 Signed MIN / -1: lo = MIN, hi = 0, flags[0]=1.
REQ-032 HOLD -> IDLE on edge where out_ready; out_valid cleared same edge.
REQ-033 Single-cycle out_valid clears on out_ready edge; new request accepted no earlier than the following edge.
REQ-034 Unsupported opcode/funct: result 0, flags 000, out_valid asserted, hi/lo unchanged.
REQ-035 Operands and instruction captured at acceptance; input changes during MUL/DIV ignored.

Reset
REQ-036 rst_n low at an edge: state IDLE, out_valid 0, result 0, flags 000, hi 0, lo 0, busy 0, iteration counter 0.
REQ-037 Reset during MUL/DIV aborts operation; no partial hi/lo write.
REQ-038 in_ready low during any edge with rst_n low; high first edge after release.

Verification (DATA_W=32)
REQ-039 add 0x00200020, a=7FFFFFFF, b=00000006 -> result 80000005, flags 011, one-cycle latency.
REQ-040 mult, a=FFFFFFFF (-1), b=00000002 -> out_valid exactly 33 edges after accept; hi FFFFFFFF, lo FFFFFFFE, flags 010.
REQ-041 divu, a=00000007, b=00000000 -> lo FFFFFFFF, hi 00000007, flags[0]=1; following mflo returns FFFFFFFF.
REQ-042 div, a=FFFFFFF9 (-7), b=00000002 -> lo FFFFFFFD, hi FFFFFFFF; out_ready held low 5 cycles -> outputs stable, in_ready 0.
REQ-043 rst_n low at cycle 10 of a mult -> next edge state IDLE, hi/lo 00000000, out_valid 0; new add accepted after release.
REQ-044 DATA_W=16 rerun: sll shamt 10 on b=0001 -> 0400; multu FFFF*FFFF -> hi FFFE, lo 0001, 17-edge latency.
